// File: rtl/mycpu_pkg.sv
// Shared constants and types for the CPU I/O port responder.
package mycpu_pkg;

  localparam logic [1:0] IO_OFS_RXDATA = 2'd0;
  localparam logic [1:0] IO_OFS_STATUS = 2'd1;
  localparam logic [1:0] IO_OFS_TXDATA = 2'd2;
  localparam logic [1:0] IO_OFS_CTRL   = 2'd3;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [3:0] rx_count;
    logic       tx_overflow;
    logic       rx_underrun;
    logic       tx_full;
    logic       rx_nonempty;
  } io_status_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head reads as zero while empty.
module io_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW:0]                  wptr, rptr;
  logic                         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_port_responder.sv
// CPU I/O window decoder mapping IOR/IOW cycles onto buffered RX/TX streams.
module io_port_responder
  import mycpu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DATA_W    = 16,
  parameter int          DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iom_in,
  input  logic              wen_in,
  input  logic [15:0]       addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  input  logic              rx_valid_in,
  input  logic [DATA_W-1:0] rx_data_in,
  output logic              rx_ready_out,
  output logic              tx_valid_out,
  output logic [DATA_W-1:0] tx_data_out,
  input  logic              tx_ready_in
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]       ofs_full;
  logic [1:0]        ofs;
  logic              in_win, rd, wr;
  logic              rd_rx, rd_status, wr_tx, flush;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic [DATA_W-1:0] rx_head;
  logic [CW-1:0]     rx_count, tx_count;
  logic              rx_underrun, tx_overflow;
  io_status_t        status;

  assign ofs_full  = addr_in - BASE_ADDR;
  assign in_win    = iom_in && (addr_in >= BASE_ADDR) && (ofs_full < 16'd4);
  assign ofs       = ofs_full[1:0];
  assign rd        = in_win && wen_in;
  assign wr        = in_win && !wen_in;
  assign rd_rx     = rd && (ofs == IO_OFS_RXDATA);
  assign rd_status = rd && (ofs == IO_OFS_STATUS);
  assign wr_tx     = wr && (ofs == IO_OFS_TXDATA);
  assign flush     = wr && (ofs == IO_OFS_CTRL) && wdata_in[0];

  assign rx_ready_out = !rx_full;
  assign tx_valid_out = !tx_empty;

  io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n),
    .push(rx_valid_in), .wdata(rx_data_in),
    .pop(rd_rx), .flush(flush),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n),
    .push(wr_tx), .wdata(wdata_in),
    .pop(tx_ready_in), .flush(flush),
    .head(tx_data_out), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  always_comb begin
    status             = '0;
    status.rx_nonempty = !rx_empty;
    status.tx_full     = tx_full;
    status.rx_underrun = rx_underrun;
    status.tx_overflow = tx_overflow;
    status.rx_count    = 4'(rx_count);
  end

  always_comb begin
    rdata_out = '0;
    if (rd_rx && !rx_empty) rdata_out = rx_head;
    if (rd_status)          rdata_out = DATA_W'(status);
  end

  // A single access per cycle, so clear-on-read never races a set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_underrun <= 1'b0;
      tx_overflow <= 1'b0;
    end else if (flush) begin
      rx_underrun <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (rd_status) begin
        rx_underrun <= 1'b0;
        tx_overflow <= 1'b0;
      end
      if (rd_rx && rx_empty) rx_underrun <= 1'b1;
      if (wr_tx && tx_full)  tx_overflow <= 1'b1;
    end
  end

  a_bus_known: assert property (@(posedge clk) disable iff (!rst_n)
    iom_in |-> !$isunknown({wen_in, addr_in}));
  a_count_rng: assert property (@(posedge clk) disable iff (!rst_n)
    (rx_count <= CW'(DEPTH)) && (tx_count <= CW'(DEPTH)));

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: expected RX/TX words queued at stimulus time.
module tb_io_port_responder;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DW    = 16;
  localparam int          DEPTH = 4;

  logic          clk, rst_n, iom, wen, rx_valid, rx_ready, tx_valid, tx_ready;
  logic [15:0]   addr;
  logic [DW-1:0] wdata, rdata, rx_data, tx_data;

  int            checks = 0, failures = 0;
  logic [DW-1:0] rx_q[$], tx_q[$];
  int            tx_model;

  io_port_responder #(.BASE_ADDR(BASE), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .iom_in(iom), .wen_in(wen), .addr_in(addr),
    .wdata_in(wdata), .rdata_out(rdata), .rx_valid_in(rx_valid), .rx_data_in(rx_data),
    .rx_ready_out(rx_ready), .tx_valid_out(tx_valid), .tx_data_out(tx_data),
    .tx_ready_in(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  // One bus cycle: drive at negedge, sample mid-low phase, release after posedge.
  task automatic bus(input logic iom_v, input logic wen_v, input logic [15:0] a,
                     input logic [DW-1:0] wd, output logic [DW-1:0] d);
    @(negedge clk);
    iom = iom_v; wen = wen_v; addr = a; wdata = wd;
    #2 d = rdata;
    @(posedge clk);
    #1 iom = 1'b0; wen = 1'b1; addr = '0; wdata = '0;
  endtask

  task automatic io_read(input logic [1:0] ofs, output logic [DW-1:0] d);
    bus(1'b1, 1'b1, BASE + 16'(ofs), '0, d);
  endtask

  task automatic io_write(input logic [1:0] ofs, input logic [DW-1:0] wd);
    logic [DW-1:0] d;
    bus(1'b1, 1'b0, BASE + 16'(ofs), wd, d);
  endtask

  task automatic rx_send(input logic [DW-1:0] d, output logic ok);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    #2 ok = rx_ready;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    if (ok) rx_q.push_back(d);
  endtask

  task automatic test_reset();
    logic ok;
    logic [DW-1:0] d;
    tx_ready = 1'b0;
    rx_send(16'h0A0A, ok);
    io_write(2'd2, 16'hAAAA);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== '0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0000", tx_data); end
    checks++; if (rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete(); tx_q.delete(); tx_model = 0;
    io_read(2'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=0000", d); end
  endtask

  task automatic test_rx_read();
    logic ok;
    logic [DW-1:0] d, e;
    rx_send(16'h1234, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rx_ready_w0 got=%b exp=1", ok); end
    rx_send(16'hBEEF, ok);
    io_read(2'd1, d);
    checks++; if (d !== 16'h0021) begin failures++; $display("FAIL rx_status_two got=%h exp=0021", d); end
    for (int i = 0; i < 2; i++) begin
      io_read(2'd0, d);
      e = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
      checks++; if (d !== e) begin failures++; $display("FAIL rx_read%0d got=%h exp=%h", i, d, e); end
    end
    io_read(2'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rx_status_drained got=%h exp=0000", d); end
  endtask

  task automatic test_underrun();
    logic [DW-1:0] d;
    io_read(2'd0, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL underrun_rdata got=%h exp=0000", d); end
    io_read(2'd1, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL underrun_status got=%h exp=0004", d); end
    io_read(2'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL underrun_cleared got=%h exp=0000", d); end
  endtask

  task automatic test_tx_overflow();
    logic [DW-1:0] d, e;
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      io_write(2'd2, DW'(i));
      if (tx_model < DEPTH) begin tx_q.push_back(DW'(i)); tx_model++; end
    end
    io_read(2'd1, d);
    checks++; if (d !== 16'h000A) begin failures++; $display("FAIL tx_status_full got=%h exp=000A", d); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      e = (tx_q.size() > 0) ? tx_q.pop_front() : 16'hDEAD;
      checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL tx_valid%0d got=%b exp=1", i, tx_valid); end
      checks++; if (tx_data !== e) begin failures++; $display("FAIL tx_data%0d got=%h exp=%h", i, tx_data, e); end
      @(negedge clk);
    end
    #2;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
    tx_ready = 1'b0; tx_model = 0;
    io_read(2'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL tx_status_after got=%h exp=0000", d); end
  endtask

  task automatic test_rx_full();
    logic ok;
    logic [DW-1:0] d, e;
    for (int i = 0; i < DEPTH; i++) rx_send(16'hA000 + 16'(i), ok);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 16'hA004;
    iom = 1'b1; wen = 1'b1; addr = BASE;
    #2;
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL rxfull_ready got=%b exp=0", rx_ready); end
    checks++; if (rdata !== e) begin failures++; $display("FAIL rxfull_pop got=%h exp=%h", rdata, e); end
    @(posedge clk);
    #1 iom = 1'b0; addr = '0;
    @(negedge clk);
    #2;
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rxfull_reready got=%b exp=1", rx_ready); end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rx_q.push_back(16'hA004);
    for (int i = 0; i < DEPTH; i++) begin
      io_read(2'd0, d);
      e = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
      checks++; if (d !== e) begin failures++; $display("FAIL rxfull_order%0d got=%h exp=%h", i, d, e); end
    end
    io_read(2'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rxfull_status got=%h exp=0000", d); end
  endtask

  task automatic test_decode();
    logic ok;
    logic [DW-1:0] d, e;
    rx_send(16'h0ABC, ok);
    bus(1'b1, 1'b1, BASE + 16'd4, '0, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL dec_above got=%h exp=0000", d); end
    bus(1'b0, 1'b1, BASE, '0, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL dec_iom0 got=%h exp=0000", d); end
    bus(1'b1, 1'b1, 16'h0001, '0, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL dec_below got=%h exp=0000", d); end
    bus(1'b0, 1'b0, BASE + 16'd2, 16'h5A5A, d);
    io_read(2'd3, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL dec_rd_ctrl got=%h exp=0000", d); end
    io_read(2'd1, d);
    checks++; if (d !== 16'h0011) begin failures++; $display("FAIL dec_status got=%h exp=0011", d); end
    io_read(2'd0, d);
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
    checks++; if (d !== e) begin failures++; $display("FAIL dec_rx got=%h exp=%h", d, e); end
  endtask

  task automatic test_flush();
    logic ok;
    logic [DW-1:0] d;
    tx_ready = 1'b0;
    io_read(2'd0, d);
    rx_send(16'h0055, ok);
    io_write(2'd2, 16'h0066);
    @(negedge clk);
    iom = 1'b1; wen = 1'b0; addr = BASE + 16'd3; wdata = 16'h0001;
    rx_valid = 1'b1; rx_data = 16'h0077;
    @(posedge clk);
    #1 iom = 1'b0; wen = 1'b1; addr = '0; wdata = '0; rx_valid = 1'b0;
    rx_q.delete(); tx_q.delete(); tx_model = 0;
    @(negedge clk);
    #2;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL flush_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL flush_rx_ready got=%b exp=1", rx_ready); end
    io_read(2'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL flush_status got=%h exp=0000", d); end
  endtask

  initial begin
    rst_n = 1'b0; iom = 1'b0; wen = 1'b1; addr = '0; wdata = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0; tx_model = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_rx_read();
    test_underrun();
    test_tx_overflow();
    test_rx_full();
    test_decode();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
